// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: Q(I.F) sample format and rounding/saturation mode encodings.
package fft_pkg;
  localparam int I_BITS = 19;
  localparam int F_BITS = 11;
  localparam int W      = I_BITS + F_BITS;

  // Q(I.F) representation of 1.0
  localparam logic signed [W-1:0] ONE = W'(2 ** F_BITS);

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  typedef enum logic {
    SAT_WRAP = 1'b0,
    SAT_CLIP = 1'b1
  } sat_mode_e;
endpackage

// File: rtl/round_sat.sv
// Combinational arithmetic right shift by SHIFT (+1 when scale), optional round-half-up,
// then reduction to OUT_W bits by wrap or clip; ovf flags any out-of-range shifted value.
module round_sat #(
  parameter int IN_W  = 63,
  parameter int OUT_W = 30,
  parameter int SHIFT = 11,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic                    scale,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);
  // One guard bit so the rounding bias can never wrap the sum.
  localparam int EW = IN_W + 1;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] bias;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shifted;
  logic [EW-OUT_W:0]    top_bits;

  always_comb begin
    ext  = {din[IN_W-1], din};
    bias = '0;
    if (ROUND != 0) begin
      bias = scale ? (EW'(1) <<< SHIFT) : (EW'(1) <<< (SHIFT - 1));
    end
    sum     = ext + bias;
    shifted = scale ? (sum >>> (SHIFT + 1)) : (sum >>> SHIFT);
    // In range exactly when the bits above the output sign bit are all copies of it.
    top_bits = shifted[EW-1:OUT_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    dout     = shifted[OUT_W-1:0];
    if (ovf && (SAT != 0)) begin
      dout = shifted[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly A +/- W*B, 3-cycle latency, 1 sample/cycle.
// A held output (OUT_VALID && !OUT_READY) freezes every stage, bubbles included, and drops IN_READY.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int I     = I_BITS,
  parameter int F     = F_BITS,
  parameter int ROUND = int'(RND_HALF_UP),
  parameter int SAT   = int'(SAT_CLIP)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                INV,
  input  logic                SCALE,
  input  logic signed [I+F-1:0] IN1_R,
  input  logic signed [I+F-1:0] IN1_I,
  input  logic signed [I+F-1:0] IN2_R,
  input  logic signed [I+F-1:0] IN2_I,
  input  logic signed [I+F-1:0] W_R,
  input  logic signed [I+F-1:0] W_I,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic signed [I+F-1:0] OUT1_R,
  output logic signed [I+F-1:0] OUT1_I,
  output logic signed [I+F-1:0] OUT2_R,
  output logic signed [I+F-1:0] OUT2_I,
  output logic                OUT_OVF,
  output logic                OVF_STICKY,
  input  logic                OVF_CLR
);
  localparam int DW = I + F;
  localparam int PW = 2 * DW + 1;
  localparam int QW = 2 * DW + 2;
  localparam int SW = 2 * DW + 3;

  logic en;
  assign en       = !(OUT_VALID && !OUT_READY);
  assign IN_READY = en;

  // Twiddle widened by one bit so conj() of the most negative W_I stays exact.
  logic signed [DW:0]   wr_x;
  logic signed [DW:0]   wi_x;
  logic signed [PW-1:0] br_e, bi_e, wr_e, wi_e;

  always_comb begin
    wr_x = {W_R[DW-1], W_R};
    wi_x = INV ? -{W_I[DW-1], W_I} : {W_I[DW-1], W_I};
    br_e = {{(DW+1){IN2_R[DW-1]}}, IN2_R};
    bi_e = {{(DW+1){IN2_I[DW-1]}}, IN2_I};
    wr_e = {{DW{wr_x[DW]}}, wr_x};
    wi_e = {{DW{wi_x[DW]}}, wi_x};
  end

  logic                 v1, sc1;
  logic signed [DW-1:0] a1_r, a1_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                 v2, sc2;
  logic signed [QW-1:0] a2_r, a2_i, pr2, pi2;

  logic signed [SW-1:0] s1_r, s1_i, s2_r, s2_i;
  logic signed [DW-1:0] r1_r, r1_i, r2_r, r2_i;
  logic [3:0]           ovf;

  always_comb begin
    s1_r = {a2_r[QW-1], a2_r} + {pr2[QW-1], pr2};
    s1_i = {a2_i[QW-1], a2_i} + {pi2[QW-1], pi2};
    s2_r = {a2_r[QW-1], a2_r} - {pr2[QW-1], pr2};
    s2_i = {a2_i[QW-1], a2_i} - {pi2[QW-1], pi2};
  end

  round_sat #(.IN_W(SW), .OUT_W(DW), .SHIFT(F), .ROUND(ROUND), .SAT(SAT)) u_rs_1r (
    .din(s1_r), .scale(sc2), .dout(r1_r), .ovf(ovf[0]));
  round_sat #(.IN_W(SW), .OUT_W(DW), .SHIFT(F), .ROUND(ROUND), .SAT(SAT)) u_rs_1i (
    .din(s1_i), .scale(sc2), .dout(r1_i), .ovf(ovf[1]));
  round_sat #(.IN_W(SW), .OUT_W(DW), .SHIFT(F), .ROUND(ROUND), .SAT(SAT)) u_rs_2r (
    .din(s2_r), .scale(sc2), .dout(r2_r), .ovf(ovf[2]));
  round_sat #(.IN_W(SW), .OUT_W(DW), .SHIFT(F), .ROUND(ROUND), .SAT(SAT)) u_rs_2i (
    .din(s2_i), .scale(sc2), .dout(r2_i), .ovf(ovf[3]));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1        <= 1'b0;
      sc1       <= 1'b0;
      a1_r      <= '0;
      a1_i      <= '0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      v2        <= 1'b0;
      sc2       <= 1'b0;
      a2_r      <= '0;
      a2_i      <= '0;
      pr2       <= '0;
      pi2       <= '0;
      OUT_VALID <= 1'b0;
      OUT1_R    <= '0;
      OUT1_I    <= '0;
      OUT2_R    <= '0;
      OUT2_I    <= '0;
      OUT_OVF   <= 1'b0;
    end else if (en) begin
      v1        <= IN_VALID;
      sc1       <= SCALE;
      a1_r      <= IN1_R;
      a1_i      <= IN1_I;
      p_rr      <= br_e * wr_e;
      p_ii      <= bi_e * wi_e;
      p_ri      <= br_e * wi_e;
      p_ir      <= bi_e * wr_e;

      v2        <= v1;
      sc2       <= sc1;
      // A moved onto the product's 2F fractional grid.
      a2_r      <= {{(QW-DW-F){a1_r[DW-1]}}, a1_r, {F{1'b0}}};
      a2_i      <= {{(QW-DW-F){a1_i[DW-1]}}, a1_i, {F{1'b0}}};
      pr2       <= {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
      pi2       <= {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

      OUT_VALID <= v2;
      OUT1_R    <= r1_r;
      OUT1_I    <= r1_i;
      OUT2_R    <= r2_r;
      OUT2_I    <= r2_i;
      OUT_OVF   <= |ovf;
    end
  end

  // A new overflow on a transfer outranks a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVF_STICKY <= 1'b0;
    end else if (OUT_VALID && OUT_READY && OUT_OVF) begin
      OVF_STICKY <= 1'b1;
    end else if (OVF_CLR) begin
      OVF_STICKY <= 1'b0;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboarded bench: a rounding/clipping instance and a truncating/wrapping instance share stimulus.
module tb_butterfly_pipe;
  import fft_pkg::*;
  localparam int DW = W;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic IN_VALID = 1'b0, INV = 1'b0, SCALE = 1'b0, OUT_READY = 1'b1, OVF_CLR = 1'b0;
  logic signed [DW-1:0] IN1_R = '0, IN1_I = '0, IN2_R = '0, IN2_I = '0, W_R = '0, W_I = '0;
  logic IN_READY, OUT_VALID, OUT_OVF, OVF_STICKY;
  logic signed [DW-1:0] OUT1_R, OUT1_I, OUT2_R, OUT2_I;
  logic t_in_ready, t_out_valid, t_out_ovf, t_ovf_sticky;
  logic signed [DW-1:0] t_out1_r, t_out1_i, t_out2_r, t_out2_i;

  always #5 CLK = ~CLK;

  butterfly_pipe dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INV(INV), .SCALE(SCALE),
    .IN1_R(IN1_R), .IN1_I(IN1_I), .IN2_R(IN2_R), .IN2_I(IN2_I), .W_R(W_R), .W_I(W_I),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT1_R(OUT1_R), .OUT1_I(OUT1_I),
    .OUT2_R(OUT2_R), .OUT2_I(OUT2_I), .OUT_OVF(OUT_OVF), .OVF_STICKY(OVF_STICKY), .OVF_CLR(OVF_CLR));

  butterfly_pipe #(.ROUND(0), .SAT(0)) dut_t (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(t_in_ready), .INV(INV), .SCALE(SCALE),
    .IN1_R(IN1_R), .IN1_I(IN1_I), .IN2_R(IN2_R), .IN2_I(IN2_I), .W_R(W_R), .W_I(W_I),
    .OUT_VALID(t_out_valid), .OUT_READY(OUT_READY), .OUT1_R(t_out1_r), .OUT1_I(t_out1_i),
    .OUT2_R(t_out2_r), .OUT2_I(t_out2_i), .OUT_OVF(t_out_ovf), .OVF_STICKY(t_ovf_sticky),
    .OVF_CLR(OVF_CLR));

  typedef struct {
    longint o1r, o1i, o2r, o2i;
    logic   ovf;
    longint t1r, t2r;
    logic   tovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input longint o1r, o1i, o2r, o2i, input logic ovf,
                              input longint t1r, t2r, input logic tovf);
    exp_t e;
    e.o1r = o1r; e.o1i = o1i; e.o2r = o2r; e.o2i = o2i; e.ovf = ovf;
    e.t1r = t1r; e.t2r = t2r; e.tovf = tovf;
    return e;
  endfunction

  // Monitor: every output transfer is checked against the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST && OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got OUT1_R=%0d with empty scoreboard", OUT1_R);
      end else begin
        mon_e = q.pop_front();
        chk("out1_r", $signed(OUT1_R), mon_e.o1r);
        chk("out1_i", $signed(OUT1_I), mon_e.o1i);
        chk("out2_r", $signed(OUT2_R), mon_e.o2r);
        chk("out2_i", $signed(OUT2_I), mon_e.o2i);
        chk("out_ovf", OUT_OVF, mon_e.ovf);
        chk("trunc_valid", t_out_valid, 1);
        chk("trunc_out1_r", $signed(t_out1_r), mon_e.t1r);
        chk("trunc_out2_r", $signed(t_out2_r), mon_e.t2r);
        chk("trunc_ovf", t_out_ovf, mon_e.tovf);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic send(input longint ar, ai, br, bi, wr, wi, input logic inv, sc, input exp_t e);
    int   guard = 0;
    logic acc   = 1'b0;
    IN1_R = DW'(ar); IN1_I = DW'(ai); IN2_R = DW'(br); IN2_I = DW'(bi);
    W_R = DW'(wr); W_I = DW'(wi); INV = inv; SCALE = sc; IN_VALID = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      guard++;
    end
    IN_VALID = 1'b0;
    if (acc) q.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no IN_READY, expected acceptance within 50 cycles");
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    @(posedge CLK);
    #1;
    chk("drain_left", q.size(), 0);
  endtask

  task automatic check_latency(input string name);
    int lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!OUT_VALID && lat < 10);
    chk(name, lat, 3);
  endtask

  function automatic exp_t bp_exp(input int k);
    longint ar = 1000 * (k + 1);
    longint ai = -7 * (k + 1);
    return mk(ar + 2048, ai, ar - 2048, ai, 1'b0, ar + 2048, ar - 2048, 1'b0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int   idx;
    int   guard;
    int   stale;
    logic acc;

    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out1_r", OUT1_R, 0);
    chk("rst_out2_i", OUT2_I, 0);
    chk("rst_out_ovf", OUT_OVF, 0);
    chk("rst_sticky", OVF_STICKY, 0);
    chk("rst_in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Identity, with first-output latency
    send(ONE, 0, ONE, 0, ONE, 0, 1'b0, 1'b0, mk(4096, 0, 0, 0, 1'b0, 4096, 0, 1'b0));
    check_latency("latency_first");
    drain();

    // Conjugate twiddle, rounding of +/- half LSB, divide-by-2 (back to back)
    send(0, 0, 0, ONE, 0, ONE, 1'b0, 1'b0, mk(-2048, 0, 2048, 0, 1'b0, -2048, 2048, 1'b0));
    send(0, 0, 0, ONE, 0, ONE, 1'b1, 1'b0, mk(2048, 0, -2048, 0, 1'b0, 2048, -2048, 1'b0));
    send(0, 0, 1, 0, 1024, 0, 1'b0, 1'b0, mk(1, 0, 0, 0, 1'b0, 0, -1, 1'b0));
    send(0, 0, -1, 0, 1024, 0, 1'b0, 1'b0, mk(0, 0, 1, 0, 1'b0, -1, 0, 1'b0));
    send(ONE, 0, ONE, 0, ONE, 0, 1'b0, 1'b1, mk(2048, 0, 0, 0, 1'b0, 2048, 0, 1'b0));
    drain();
    chk("sticky_idle", OVF_STICKY, 0);

    // Saturation vs wrap, sticky set, clear
    send(536870911, 0, ONE, 0, ONE, 0, 1'b0, 1'b0,
         mk(536870911, 0, 536868863, 0, 1'b1, -536868865, 536868863, 1'b1));
    drain();
    chk("sticky_set", OVF_STICKY, 1);
    OVF_CLR = 1'b1;
    @(posedge CLK); #1;
    OVF_CLR = 1'b0;
    chk("sticky_clr", OVF_STICKY, 0);

    // Clear coinciding with an overflowing transfer: set wins
    OUT_READY = 1'b0;
    send(536870911, 0, ONE, 0, ONE, 0, 1'b0, 1'b0,
         mk(536870911, 0, 536868863, 0, 1'b1, -536868865, 536868863, 1'b1));
    repeat (3) begin @(posedge CLK); #1; end
    chk("held_ovf_valid", OUT_VALID, 1);
    OUT_READY = 1'b1;
    OVF_CLR   = 1'b1;
    @(posedge CLK); #1;
    OVF_CLR = 1'b0;
    chk("sticky_set_wins", OVF_STICKY, 1);
    drain();

    // Backpressure: six back-to-back samples into a stalled output
    OUT_READY = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      IN1_R = DW'(1000 * (idx + 1)); IN1_I = DW'(-7 * (idx + 1));
      IN2_R = ONE; IN2_I = '0; W_R = ONE; W_I = '0; INV = 1'b0; SCALE = 1'b0;
      IN_VALID = 1'b1;
      @(negedge CLK);
      acc = IN_READY;
      if (acc) q.push_back(bp_exp(idx));
      @(posedge CLK); #1;
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_in_ready", IN_READY, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("bp_hold_valid", OUT_VALID, 1);
      chk("bp_hold_out1_r", $signed(OUT1_R), 3048);
      chk("bp_hold_out2_r", $signed(OUT2_R), -1048);
      chk("bp_hold_out1_i", $signed(OUT1_I), -7);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    guard = 0;
    while (idx < 6 && guard < 50) begin
      IN1_R = DW'(1000 * (idx + 1)); IN1_I = DW'(-7 * (idx + 1));
      IN_VALID = 1'b1;
      @(negedge CLK);
      acc = IN_READY;
      if (acc) q.push_back(bp_exp(idx));
      @(posedge CLK); #1;
      if (acc) idx++;
      guard++;
    end
    IN_VALID = 1'b0;
    chk("bp_all_sent", idx, 6);
    drain();

    // Reset mid-flight: first sample sits on the output when reset hits
    send(11, 0, ONE, 0, ONE, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1'b0, 0, 0, 1'b0));
    send(22, 0, ONE, 0, ONE, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1'b0, 0, 0, 1'b0));
    @(posedge CLK); #1;
    chk("pre_rst_valid", OUT_VALID, 1);
    RST = 1'b0;
    #1;
    chk("rst_mid_valid", OUT_VALID, 0);
    chk("rst_mid_sticky", OVF_STICKY, 0);
    q.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (OUT_VALID) stale++;
    end
    chk("stale_outputs", stale, 0);
    @(posedge CLK); #1;
    send(100, 200, ONE, 0, 0, ONE, 1'b0, 1'b0, mk(100, 2248, 100, -1848, 1'b0, 100, 100, 1'b0));
    check_latency("latency_after_reset");
    drain();

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
